// File: rtl/dmux_4_way_arbiter.sv
// dmux_4_way_arbiter: round-robin arbiter driving a dmux_4_way sel/data pair; ARB_PREEMPT_EN enables HOLD_MAX forced release.
module dmux_4_way_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);
`ifdef ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [3:0] grant_nx;
  logic [1:0] sel_nx, last, last_nx, p1, p2, p3, w;
  logic [7:0] hold_cnt, hold_nx;
  logic       busy_nx, timeout_nx, expire;
  assign p1 = last + 2'd1;
  assign p2 = last + 2'd2;
  assign p3 = last + 2'd3;
  assign w = req[p1] ? p1 : req[p2] ? p2 : req[p3] ? p3 : last;
  assign expire = PREEMPT && hold_cnt == 8'(HOLD_MAX - 1);
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    sel_nx     = sel;
    busy_nx    = busy;
    last_nx    = last;
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_nx = GRANT;
        sel_nx   = w;
        grant_nx = 4'b0001 << w;
        busy_nx  = 1'b1;
        hold_nx  = 8'd0;
      end
      GRANT: if (!req[sel] || expire) begin
        state_nx   = RELEASE;
        grant_nx   = 4'b0000;
        busy_nx    = 1'b0;
        timeout_nx = req[sel];
      end else begin
        hold_nx = hold_cnt == 8'hff ? hold_cnt : hold_cnt + 8'd1;
      end
      RELEASE: begin
        state_nx = IDLE;
        last_nx  = sel;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
    end
  end
endmodule

// File: doc/dmux_4_way_arbiter.md
Name: dmux_4_way_arbiter

Overview:
- Round-robin arbiter that shares one dmux_4_way datapath between four requesters.
- Picks one requester and drives the dmux select.
- Asserts the dmux data input while a grant is active, so exactly one dmux output, the grant line, is high.
- Sits directly in front of dmux_4_way; its sel/busy outputs connect to the dmux sel/a inputs.

Parameters:
- HOLD_MAX, 4: maximum consecutive grant cycles per requester before forced release. Used only with ARB_PREEMPT_EN. Legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  level requests; req[i] is held high for as long as requester i wants the resource
- grant  output  4  one-hot grant, registered; 0000 when no grant is active
- sel  output  2  registered index of the current or last winner; feeds dmux_4_way sel
- busy  output  1  high while in GRANT; feeds dmux_4_way data input
- timeout  output  1  one-cycle pulse marking a forced release

Behaviour:
- One clock and one reset; reset is synchronous and active-high. All outputs are registered.
- Reset values: grant=0000, sel=00, busy=0, timeout=0, state=IDLE, last=2'd3, hold_cnt=0.
- Reset has priority over every other event. Reset asserted mid-grant gives grant=0000 on the next edge, with no RELEASE cycle.
- Internal state: 2-bit round-robin pointer last; 8-bit hold_cnt.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0000, stay in IDLE; sel holds its value.
  - Otherwise search indices last+1, last+2, last+3, last+4, all mod 4, and take the first with req set as winner w.
  - Next edge: sel=w, grant=1<<w, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled high to grant visible: 1 cycle.
- GRANT:
  - grant, sel and busy stay stable.
  - If req[sel]==0 at the edge, go to RELEASE.
  - Else if ARB_PREEMPT_EN is defined and hold_cnt==HOLD_MAX-1, go to RELEASE and set timeout=1 for that one cycle.
  - Else hold_cnt increments. It saturates and never wraps.
- RELEASE:
  - grant=0000, busy=0, last=sel, state=IDLE.
  - Exactly one cycle.
  - Dead time between consecutive grants is 2 cycles: the RELEASE cycle plus the IDLE decision cycle.
- Requests from non-granted requesters arriving during GRANT are not acted on until IDLE.
- A granted requester re-raising req after RELEASE competes normally. With other requests pending, it is lowest priority because last equals its index.
- A single persistent requester that is force-released is regranted after the 2 dead cycles.
- grant always equals one-hot(sel) when busy=1, and 0000 when busy=0.

Optional Feature:
- Macro: ARB_PREEMPT_EN.
- Defined: the HOLD_MAX forced release is active. A grant lasts at most HOLD_MAX cycles, and timeout pulses on each forced release.
- Undefined: a grant is held until req[sel] drops. HOLD_MAX is ignored and timeout is tied to 0.

Test Plan:
- Reset: reset=1 for 2 cycles with req=1111 -> grant=0000, sel=00, busy=0, timeout=0 throughout. After release of reset, the first grant is 0001, one cycle after the first edge in IDLE.
- Single requester, no preempt: req=0100 raised at edge 0 -> grant=0100, sel=10, busy=1 from edge 1. req dropped before edge 5 -> grant=0000 after edge 5, and IDLE after edge 6.
- Round-robin with preempt, HOLD_MAX=4, req=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 4 cycles with a 2-cycle gap, and timeout pulses after each grant.
- Skip logic: after a grant to index 1 releases, apply req=1001 -> next grant 1000 (sel=11); after that releases, 0001 (sel=00).
- No preempt, req=1111 held for 20 cycles -> grant=0001 for all 20 cycles and timeout stays 0.
- Reset mid-grant: with grant=0100 active, pulse reset for 1 cycle and keep req=1111 -> grant=0000 on the next edge. The pointer returns to 3, so the next grant is 0001.
